// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_ctrl
// Description : Boot-time owner of the instruction memory. Receives a
//               length-prefixed, big-endian program over the UART byte
//               stream, writes it word by word into instruction memory, then
//               hands the read port to IF fetch and releases the CPU.
//               A Boot_Req pulse restarts the load from any state.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_ctrl #(
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] PC_BASE = 32'h0000_3000,
  parameter int          TIMEOUT = 100000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Boot_Req,
  input  logic              Rx_Valid,
  input  logic [7:0]        Rx_Data,
  input  logic [31:0]       Fetch_PC,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  output logic              Mem_WE,
  output logic              Enable,
  output logic              Cpu_Reset,
  output logic              Load_Done,
  output logic              Load_Err,
  output logic [15:0]       Word_Cnt
);

  localparam int                 c_IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);
  // Largest legal program length in words (the full memory).
  localparam logic [16:0]        c_MAX_LEN   = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_len;
  logic [23:0]         r_asm;
  logic [31:0]         r_wdata;
  logic                r_wr_pend;
  logic [ADDR_W-1:0]   r_waddr;
  logic [15:0]         r_word_cnt;
  logic [1:0]          r_byte_idx;
  logic [c_IDLE_W-1:0] r_idle;
  logic                r_was_run;

  logic [15:0]         w_len_full;
  logic                w_idle_expire;
  logic [31:0]         w_pc_off;
  logic                w_unused_pc_bits;

  assign w_len_full       = {r_len[15:8], Rx_Data};
  assign w_idle_expire    = !Rx_Valid && (r_idle == c_IDLE_LAST);
  assign w_pc_off         = Fetch_PC - PC_BASE;
  assign w_unused_pc_bits = ^{w_pc_off[31:ADDR_W+2], w_pc_off[1:0]};

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next_state = r_state;
    Enable       = 1'b0;
    Cpu_Reset    = 1'b1;
    Load_Err     = 1'b0;
    Load_Done    = 1'b0;
    Mem_Addr     = r_waddr;
    // A boot request in the write cycle kills the write.
    Mem_WE       = r_wr_pend && !Boot_Req;

    if (Boot_Req) begin
      w_next_state = S_LEN0;
    end else begin
      case (r_state)
        S_LEN0: if (Rx_Valid) w_next_state = S_LEN1;
        S_LEN1: begin
          if (Rx_Valid) begin
            if (w_len_full == 16'd0)                  w_next_state = S_RUN;
            else if ({1'b0, w_len_full} > c_MAX_LEN)  w_next_state = S_ERR;
            else                                      w_next_state = S_DATA;
          end else if (w_idle_expire) begin
            w_next_state = S_ERR;
          end
        end
        S_DATA: begin
          if ((r_word_cnt == r_len) && !r_wr_pend) w_next_state = S_RUN;
          else if (w_idle_expire)                  w_next_state = S_ERR;
        end
        default: w_next_state = r_state;
      endcase
    end

    if (r_state == S_RUN) begin
      Enable    = 1'b1;
      Cpu_Reset = 1'b0;
      Load_Done = !r_was_run;
      Mem_Addr  = w_pc_off[ADDR_W+1:2];
    end
    if (r_state == S_ERR) begin
      Load_Err = 1'b1;
    end
  end

  // Length capture, word assembly, write sequencing and idle timing.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_len      <= '0;
      r_asm      <= '0;
      r_wdata    <= '0;
      r_wr_pend  <= 1'b0;
      r_waddr    <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_idle     <= '0;
      r_was_run  <= 1'b0;
    end else begin
      r_was_run <= (r_state == S_RUN);
      if (Boot_Req) begin
        r_wr_pend  <= 1'b0;
        r_waddr    <= '0;
        r_word_cnt <= '0;
        r_byte_idx <= '0;
        r_idle     <= '0;
      end else begin
        // The write cycle ends on this edge: advance address and count.
        if (r_wr_pend) begin
          r_wr_pend  <= 1'b0;
          r_waddr    <= r_waddr + 1'b1;
          r_word_cnt <= r_word_cnt + 16'd1;
        end
        case (r_state)
          S_LEN0: begin
            r_idle <= '0;
            if (Rx_Valid) r_len[15:8] <= Rx_Data;
          end
          S_LEN1: begin
            if (Rx_Valid) begin
              r_len[7:0] <= Rx_Data;
              r_idle     <= '0;
              r_byte_idx <= '0;
            end else begin
              r_idle <= r_idle + 1'b1;
            end
          end
          S_DATA: begin
            if (Rx_Valid) begin
              r_idle     <= '0;
              r_byte_idx <= r_byte_idx + 2'd1;
              if (r_byte_idx == 2'd3) begin
                r_wdata   <= {r_asm, Rx_Data};
                r_wr_pend <= 1'b1;
              end else begin
                r_asm <= {r_asm[15:0], Rx_Data};
              end
            end else begin
              r_idle <= r_idle + 1'b1;
            end
          end
          default: r_idle <= '0;
        endcase
      end
    end
  end

  assign Mem_WData = r_wdata;
  assign Word_Cnt  = r_word_cnt;

endmodule
`default_nettype wire
